// File: rtl/fmcropping.sv
// Feature-map cropping: consumes a SIMD-folded feature map stream and forwards only
// the words whose X/Y position lies inside a runtime-configurable window.
module fmcropping #(
    parameter int XCOUNTER_BITS = 8,
    parameter int YCOUNTER_BITS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int SIMD          = 2,
    parameter int ELEM_BITS     = 8,
    parameter int INIT_XON      = 1,
    parameter int INIT_XOFF     = 5,
    parameter int INIT_XEND     = 5,
    parameter int INIT_YON      = 1,
    parameter int INIT_YOFF     = 5,
    parameter int INIT_YEND     = 5,
    localparam int STREAM_BITS  = 8 * ((SIMD * ELEM_BITS + 7) / 8)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   we,
    input  logic [2:0]             wa,
    input  logic [31:0]            wd,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tvalid,
    input  logic [STREAM_BITS-1:0] s_axis_tdata,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [STREAM_BITS-1:0] m_axis_tdata
);

    localparam int SF    = NUM_CHANNELS / SIMD;
    localparam int SBITS = (SF > 1) ? $clog2(SF) : 1;
    localparam logic [SBITS-1:0] S_LAST = SBITS'(SF - 1);

    if (NUM_CHANNELS < 1 || (NUM_CHANNELS % SIMD) != 0) begin : g_bad_channels
        $error("fmcropping: NUM_CHANNELS must be >= 1 and a multiple of SIMD");
    end
    if (INIT_XON >= (1 << XCOUNTER_BITS) || INIT_XOFF >= (1 << XCOUNTER_BITS) ||
        INIT_XEND >= (1 << XCOUNTER_BITS)) begin : g_bad_xinit
        $error("fmcropping: INIT_X* value exceeds XCOUNTER_BITS");
    end
    if (INIT_YON >= (1 << YCOUNTER_BITS) || INIT_YOFF >= (1 << YCOUNTER_BITS) ||
        INIT_YEND >= (1 << YCOUNTER_BITS)) begin : g_bad_yinit
        $error("fmcropping: INIT_Y* value exceeds YCOUNTER_BITS");
    end
    if (INIT_XOFF <= INIT_XON || INIT_YOFF <= INIT_YON) begin : g_empty_window
        $warning("fmcropping: initial crop window is empty");
    end

    logic [XCOUNTER_BITS-1:0] xon_q, xon_d, xoff_q, xoff_d, xend_q, xend_d;
    logic [YCOUNTER_BITS-1:0] yon_q, yon_d, yoff_q, yoff_d, yend_q, yend_d;
    logic [SBITS-1:0]         s_cnt_q, s_cnt_d;
    logic [XCOUNTER_BITS-1:0] x_cnt_q, x_cnt_d;
    logic [YCOUNTER_BITS-1:0] y_cnt_q, y_cnt_d;
    logic                     a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic [STREAM_BITS-1:0]   a_dat_q, a_dat_d, b_dat_q, b_dat_d;

    logic hs, xen, yen, fwd;
    logic unused_wd;

    assign unused_wd = ^wd;

    always_comb begin
        xon_d  = xon_q;
        xoff_d = xoff_q;
        xend_d = xend_q;
        yon_d  = yon_q;
        yoff_d = yoff_q;
        yend_d = yend_q;
        if (we) begin
            case (wa)
                3'd0:    xon_d  = wd[XCOUNTER_BITS-1:0];
                3'd1:    xoff_d = wd[XCOUNTER_BITS-1:0];
                3'd2:    xend_d = wd[XCOUNTER_BITS-1:0];
                3'd4:    yon_d  = wd[YCOUNTER_BITS-1:0];
                3'd5:    yoff_d = wd[YCOUNTER_BITS-1:0];
                3'd6:    yend_d = wd[YCOUNTER_BITS-1:0];
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge ap_clk) begin
        if (ap_rst_n && we && (wa == 3'd3 || wa == 3'd7))
            $warning("fmcropping: illegal config address %0d ignored", wa);
    end
`endif

    // Window decision uses the position of the current word, before the counters step.
    always_comb begin
        hs  = s_axis_tvalid && s_axis_tready;
        xen = hs && (s_cnt_q == '0);
        yen = xen && (x_cnt_q == xend_q);
        fwd = (x_cnt_q >= xon_q) && (x_cnt_q < xoff_q) &&
              (y_cnt_q >= yon_q) && (y_cnt_q < yoff_q);

        s_cnt_d = s_cnt_q;
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        if (hs)
            s_cnt_d = (s_cnt_q == '0) ? S_LAST : s_cnt_q - 1'b1;
        if (xen)
            x_cnt_d = (x_cnt_q == xend_q) ? '0 : x_cnt_q + 1'b1;
        if (yen)
            y_cnt_d = (y_cnt_q == yend_q) ? '0 : y_cnt_q + 1'b1;
    end

    // A handshake implies A is empty, so a new word may always overwrite B after the A->B move.
    always_comb begin
        a_vld_d = a_vld_q;
        a_dat_d = a_dat_q;
        b_vld_d = b_vld_q;
        b_dat_d = b_dat_q;
        if (!b_vld_q || m_axis_tready) begin
            b_vld_d = a_vld_q;
            b_dat_d = a_dat_q;
            a_vld_d = 1'b0;
        end
        if (hs && fwd) begin
            if (!b_vld_q || m_axis_tready) begin
                b_vld_d = 1'b1;
                b_dat_d = s_axis_tdata;
            end else begin
                a_vld_d = 1'b1;
                a_dat_d = s_axis_tdata;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            xon_q   <= XCOUNTER_BITS'(INIT_XON);
            xoff_q  <= XCOUNTER_BITS'(INIT_XOFF);
            xend_q  <= XCOUNTER_BITS'(INIT_XEND);
            yon_q   <= YCOUNTER_BITS'(INIT_YON);
            yoff_q  <= YCOUNTER_BITS'(INIT_YOFF);
            yend_q  <= YCOUNTER_BITS'(INIT_YEND);
            s_cnt_q <= S_LAST;
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            a_vld_q <= 1'b0;
            a_dat_q <= '0;
            b_vld_q <= 1'b0;
            b_dat_q <= '0;
        end else begin
            xon_q   <= xon_d;
            xoff_q  <= xoff_d;
            xend_q  <= xend_d;
            yon_q   <= yon_d;
            yoff_q  <= yoff_d;
            yend_q  <= yend_d;
            s_cnt_q <= s_cnt_d;
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
            a_vld_q <= a_vld_d;
            a_dat_q <= a_dat_d;
            b_vld_q <= b_vld_d;
            b_dat_q <= b_dat_d;
        end
    end

    assign s_axis_tready = !a_vld_q;
    assign m_axis_tvalid = b_vld_q;
    assign m_axis_tdata  = b_dat_q;

endmodule

// File: tb/tb_fmcropping.sv
// Directed bench for fmcropping: table of crop windows applied to a 6x6, SF=2 frame,
// plus hand-written sequences for illegal writes, mid-frame YEnd change and async reset.
module tb_fmcropping;

    localparam int SB = 16;
    localparam int SF = 2;
    localparam int FRAME = 72;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          we = 1'b0;
    logic [2:0]    wa = '0;
    logic [31:0]   wd = '0;
    logic          s_axis_tready;
    logic          s_axis_tvalid = 1'b0;
    logic [SB-1:0] s_axis_tdata = '0;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tvalid;
    logic [SB-1:0] m_axis_tdata;

    fmcropping dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .we            (we),
        .wa            (wa),
        .wd            (wd),
        .s_axis_tready (s_axis_tready),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stall_cnt = 0;
    logic [SB-1:0] got[$];
    logic [SB-1:0] exp_q[$];
    int in_edges[$];
    int out_edges[$];
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [SB-1:0] prev_d = '0;

    typedef struct {
        int xon, xoff, yon, yoff;
        int mode;   // 0: sink always ready, 1: sink ready 50%
        int nfr;
        int cnt, first, last;
        bit lat;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(posedge ap_clk) cyc = cyc + 1;

    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (s_axis_tvalid && s_axis_tready) in_edges.push_back(cyc + 1);
            if (s_axis_tvalid && !s_axis_tready) stall_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                got.push_back(m_axis_tdata);
                out_edges.push_back(cyc + 1);
            end
            if (prev_v && !prev_r) begin
                check("hold_valid", 32'(m_axis_tvalid), 32'd1);
                check("hold_data", 32'(m_axis_tdata), 32'(prev_d));
            end
            prev_v = m_axis_tvalid;
            prev_r = m_axis_tready;
            prev_d = m_axis_tdata;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic clear_logs();
        got.delete();
        exp_q.delete();
        in_edges.delete();
        out_edges.delete();
        stall_cnt = 0;
    endtask

    task automatic cfg_write(input int addr, input int data);
        we = 1'b1;
        wa = 3'(addr);
        wd = 32'(data);
        @(posedge ap_clk); #1;
        we = 1'b0;
    endtask

    // mode 0: sink ready, 1: random sink ready, 2: sink stalled
    task automatic drive_words(input int start, input int n, input int mode);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 4000) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = SB'((start + i) % FRAME);
            m_axis_tready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge ap_clk);
            if (s_axis_tready) i++;
            @(posedge ap_clk); #1;
            guard++;
        end
        s_axis_tvalid = 1'b0;
        if (i < n) check("drive_timeout", 32'(i), 32'(n));
    endtask

    task automatic drain();
        m_axis_tready = 1'b1;
        repeat (6) @(posedge ap_clk);
        #1;
    endtask

    // Reference cropping: position of word i counted from the frame origin.
    function automatic void add_exp(input int xon, input int xoff, input int yon, input int yoff,
                                    input int xend, input int yend, input int n);
        for (int i = 0; i < n; i++) begin
            int x, y;
            x = (i / SF) % (xend + 1);
            y = (i / (SF * (xend + 1))) % (yend + 1);
            if (x >= xon && x < xoff && y >= yon && y < yoff)
                exp_q.push_back(SB'(i % FRAME));
        end
    endfunction

    task automatic cmp_seq(input string name);
        int mism = 0;
        int n;
        check({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            if (got[k] !== exp_q[k]) mism++;
        check({name, "_data_mismatches"}, 32'(mism), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{1, 5, 1, 5, 0, 2, 64, 14, 57, 1'b0};
        vecs[1] = '{1, 5, 1, 5, 1, 1, 32, 14, 57, 1'b0};
        vecs[2] = '{0, 6, 0, 6, 0, 1, 72,  0, 71, 1'b1};
        vecs[3] = '{3, 3, 1, 5, 0, 1,  0, -1, -1, 1'b0};
        vecs[4] = '{1, 5, 1, 5, 0, 1, 32, 14, 57, 1'b0};
        vecs[5] = '{0, 2, 4, 6, 0, 1,  8, 48, 63, 1'b0};
        vecs[6] = '{5, 9, 0, 1, 0, 1,  2, 10, 11, 1'b0};
        vecs[7] = '{2, 3, 5, 6, 0, 1,  2, 64, 65, 1'b0};

        #1;
        check("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        check("reset_s_tready", 32'(s_axis_tready), 32'd1);

        for (int r = 0; r < 8; r++) begin
            cfg_write(0, vecs[r].xon);
            cfg_write(1, vecs[r].xoff);
            cfg_write(4, vecs[r].yon);
            cfg_write(5, vecs[r].yoff);
            clear_logs();
            drive_words(0, vecs[r].nfr * FRAME, vecs[r].mode);
            drain();
            check($sformatf("v%0d_count", r), 32'(got.size()), 32'(vecs[r].cnt));
            if (vecs[r].cnt > 0 && got.size() > 0) begin
                check($sformatf("v%0d_first", r), 32'(got[0]), 32'(vecs[r].first));
                check($sformatf("v%0d_last", r), 32'(got[got.size()-1]), 32'(vecs[r].last));
            end
            add_exp(vecs[r].xon, vecs[r].xoff, vecs[r].yon, vecs[r].yoff, 5, 5, vecs[r].nfr * FRAME);
            cmp_seq($sformatf("v%0d_seq", r));
            if (vecs[r].mode == 0)
                check($sformatf("v%0d_input_stalls", r), 32'(stall_cnt), 32'd0);
            if (vecs[r].lat && out_edges.size() == FRAME && in_edges.size() == FRAME) begin
                check("lat_first", 32'(out_edges[0] - in_edges[0]), 32'd1);
                check("lat_last", 32'(out_edges[FRAME-1] - in_edges[FRAME-1]), 32'd1);
                check("throughput_span", 32'(out_edges[FRAME-1] - out_edges[0]), 32'(FRAME - 1));
            end
        end

        // Illegal addresses must not disturb the window (window is 1..5 from the last restore).
        cfg_write(0, 1); cfg_write(1, 5); cfg_write(4, 1); cfg_write(5, 5);
        cfg_write(3, 0);
        cfg_write(7, 0);
        clear_logs();
        drive_words(0, FRAME, 0);
        drain();
        check("illegal_wa_count", 32'(got.size()), 32'd32);
        if (got.size() > 0) check("illegal_wa_first", 32'(got[0]), 32'd14);

        // YEnd lowered to 2 while YCount==1: frame is then 36 words long.
        clear_logs();
        drive_words(0, 20, 0);
        cfg_write(6, 2);
        drive_words(20, 16, 0);
        drain();
        add_exp(1, 5, 1, 5, 5, 2, 36);
        check("yend_count", 32'(got.size()), 32'd16);
        if (got.size() > 0) check("yend_last", 32'(got[got.size()-1]), 32'd33);
        cmp_seq("yend_seq");
        cfg_write(6, 5);
        clear_logs();
        drive_words(0, FRAME, 0);
        drain();
        check("after_yend_count", 32'(got.size()), 32'd32);
        if (got.size() > 0) check("after_yend_first", 32'(got[0]), 32'd14);

        // Fill B and A with the sink stalled, then reset mid-frame.
        clear_logs();
        drive_words(0, 16, 2);
        check("full_m_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("full_s_tready", 32'(s_axis_tready), 32'd0);
        @(negedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("rst_async_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(posedge ap_clk); #1;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        check("rst_release_s_tready", 32'(s_axis_tready), 32'd1);
        clear_logs();
        drive_words(0, FRAME, 0);
        drain();
        add_exp(1, 5, 1, 5, 5, 5, FRAME);
        cmp_seq("post_reset_seq");
        if (got.size() > 0) check("post_reset_first", 32'(got[0]), 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
